// File: rtl/ides_word_align.sv
// ides_word_align
// Word aligner for a 10-bit LSB-first serial stream delivered two bits per
// clock by a DDR input cell. It hunts for SYNC_WORD at every bit offset,
// verifies LOCK_COUNT consecutive aligned tokens, and then emits one aligned
// word every five clocks. Lock is dropped after TIMEOUT_WORDS words without
// an aligned token, or on request.
//
// Ports
//   clk_i       single clock, rising edge
//   rst_n_i     asynchronous active-low reset (release synchronized upstream)
//   data_i      two received bits per clock, data_i[0] is the earlier bit
//   realign_i   1-cycle pulse: drop lock and re-hunt on the next edge
//   word_o      aligned word, bit 0 earliest
//   word_vld_o  1-cycle strobe marking word_o valid (only while locked)
//   sync_o      set with word_vld_o when word_o == SYNC_WORD
//   locked_o    high in state LOCKED
//   phase_o     selected bit offset 0..9, held until the next hunt match
//
// Handshake: word_vld_o is a pure valid strobe with no ready; the consumer
// must take word_o/sync_o in the cycle word_vld_o is high.
module ides_word_align #(
  parameter logic [9:0] SYNC_WORD     = 10'b1101010100,
  parameter int         LOCK_COUNT    = 4,
  parameter int         TIMEOUT_WORDS = 1024
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] data_i,
  input  logic       realign_i,
  output logic [9:0] word_o,
  output logic       word_vld_o,
  output logic       sync_o,
  output logic       locked_o,
  output logic [3:0] phase_o
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [4:0]  LOCK_CNT = 5'(LOCK_COUNT);
  localparam logic [16:0] TMO_CNT  = 17'(TIMEOUT_WORDS);

  logic [1:0]  state_q;
  logic [8:0]  hist_q;   // bits 2k-9 .. 2k-1 at edge k, [8] newest
  logic [2:0]  warm_q;   // sampling edges since reset, saturates at 5
  logic [3:0]  pos_q;    // (2k) mod 10: 0,2,4,6,8
  logic [3:0]  phase_q;
  logic [3:0]  mcnt_q;   // consecutive aligned matches while verifying
  logic [15:0] tcnt_q;   // words since last aligned token while locked

  // Together with the incoming pair the history gives the last 11 bits:
  // cat[0] = bit 2k-9 ... cat[9] = bit 2k, cat[10] = bit 2k+1.
  logic [10:0] cat;
  logic [9:0]  win_lo;   // W(2k)
  logic [9:0]  win_hi;   // W(2k+1)
  logic        hunt_lo;
  logic        hunt_hi;
  logic        bnd_lo;
  logic        bnd_hi;
  logic        bnd;
  logic [9:0]  bnd_win;
  logic        bnd_match;
  logic [4:0]  mcnt_inc;
  logic [16:0] tcnt_inc;

  always_comb begin
    cat       = {data_i, hist_q};
    win_lo    = cat[9:0];
    win_hi    = cat[10:1];
    // W(n) only exists once bits n-9..n have all been received (n >= 9).
    hunt_lo   = (warm_q >= 3'd5) && (win_lo == SYNC_WORD);
    hunt_hi   = (warm_q >= 3'd4) && (win_hi == SYNC_WORD);
    // Exactly one of the two candidate bits can be a boundary, once per
    // five clocks, because pos_q only takes even values.
    bnd_lo    = (phase_q == pos_q);
    bnd_hi    = (phase_q == pos_q + 4'd1);
    bnd       = bnd_lo | bnd_hi;
    bnd_win   = bnd_lo ? win_lo : win_hi;
    bnd_match = (bnd_win == SYNC_WORD);
    mcnt_inc  = {1'b0, mcnt_q} + 5'd1;
    tcnt_inc  = {1'b0, tcnt_q} + 17'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_HUNT;
      hist_q     <= '0;
      warm_q     <= '0;
      pos_q      <= '0;
      phase_q    <= '0;
      mcnt_q     <= '0;
      tcnt_q     <= '0;
      word_o     <= '0;
      word_vld_o <= 1'b0;
      sync_o     <= 1'b0;
    end else begin
      hist_q     <= cat[10:2];
      if (warm_q != 3'd5) warm_q <= warm_q + 3'd1;
      pos_q      <= (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd2;
      word_vld_o <= 1'b0;
      sync_o     <= 1'b0;

      if (realign_i) begin
        // Overrides any match, boundary or timeout seen on this edge.
        state_q <= ST_HUNT;
        mcnt_q  <= '0;
        tcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (hunt_lo || hunt_hi) begin
              // Lower n wins when both candidates match.
              phase_q <= hunt_lo ? pos_q : pos_q + 4'd1;
              mcnt_q  <= 4'd1;
              tcnt_q  <= '0;
              state_q <= (LOCK_CNT == 5'd1) ? ST_LOCKED : ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (bnd) begin
              if (bnd_match) begin
                if (mcnt_q != 4'hF) mcnt_q <= mcnt_inc[3:0];
                if (mcnt_inc >= LOCK_CNT) begin
                  state_q <= ST_LOCKED;
                  tcnt_q  <= '0;
                end
              end else begin
                state_q <= ST_HUNT;
                mcnt_q  <= '0;
              end
            end
          end
          ST_LOCKED: begin
            // Only the boundary window is examined, so a misaligned token
            // can neither refresh the timeout nor move the phase.
            if (bnd) begin
              word_o     <= bnd_win;
              word_vld_o <= 1'b1;
              sync_o     <= bnd_match;
              if (bnd_match) begin
                tcnt_q <= '0;
              end else if (tcnt_inc >= TMO_CNT) begin
                state_q <= ST_HUNT;
                mcnt_q  <= '0;
                tcnt_q  <= '0;
              end else if (tcnt_q != 16'hFFFF) begin
                tcnt_q <= tcnt_inc[15:0];
              end
            end
          end
          default: begin
            state_q <= ST_HUNT;
            mcnt_q  <= '0;
            tcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign locked_o = (state_q == ST_LOCKED);
  assign phase_o  = phase_q;

endmodule

// File: tb/tb_ides_word_align.sv
module tb_ides_word_align;

  localparam logic [9:0] SYNC = 10'b1101010100;
  localparam logic [9:0] FILL = 10'h0F0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] data;
  logic       realign;
  logic [9:0] word;
  logic       word_vld;
  logic       sync;
  logic       locked;
  logic [3:0] phase;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];   // {sync, word}
  logic        bit_q[$];   // serial stream, earliest bit first
  logic        prev_vld = 1'b0;

  ides_word_align dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .data_i     (data),
    .realign_i  (realign),
    .word_o     (word),
    .word_vld_o (word_vld),
    .sync_o     (sync),
    .locked_o   (locked),
    .phase_o    (phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n   = 1'b0;
    data    = 2'b00;
    realign = 1'b0;
    bit_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // drivers
  task automatic push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bit_q.push_back(w[i]);
  endtask

  task automatic push_exp(input logic s, input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({s, w});
  endtask

  task automatic send_pair(input logic [1:0] d, input logic ra);
    data    = d;
    realign = ra;
    @(posedge clk);
    #1;
    realign = 1'b0;
  endtask

  // Sends queued bits until at most keep pairs remain (odd tail padded with 0).
  task automatic send_bits(input int keep);
    logic b0;
    logic b1;
    while (bit_q.size() > 2 * keep) begin
      b0 = bit_q.pop_front();
      b1 = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
      send_pair({b1, b0}, 1'b0);
    end
  endtask

  task automatic lock_seq();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    send_bits(0);
  endtask

  // scoreboard: compares every strobe against the expected queue
  always @(negedge clk) begin
    logic [10:0] e;
    if (word_vld) begin
      checks++;
      if (prev_vld) begin
        failures++;
        $display("FAIL vld_strobe: word_vld high two cycles in a row, got word=%h, required single-cycle strobe", word);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got sync=%b word=%h, required no word_vld", sync, word);
      end else begin
        e = exp_q.pop_front();
        if ({sync, word} !== e) begin
          failures++;
          $display("FAIL word: got sync=%b word=%h, required sync=%b word=%h", sync, word, e[10], e[9:0]);
        end
      end
    end
    prev_vld = word_vld;
  end

  task automatic test_reset();
    rst_n   = 1'b0;
    data    = 2'b11;
    realign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({word, word_vld, sync, locked, phase} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got word=%h vld=%b sync=%b locked=%b phase=%0d, required all 0",
               word, word_vld, sync, locked, phase);
    end
    do_reset();
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_locked: got %b required 0", locked);
    end
  endtask

  task automatic test_lock_offset0();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(SYNC);
    send_bits(1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_early: got locked=%b required 0 before 4th token", locked);
    end
    send_bits(0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_after_4: got locked=%b required 1", locked);
    end
    checks++;
    if (phase !== 4'd9) begin
      failures++;
      $display("FAIL phase_offset0: got %0d required 9", phase);
    end
    push_exp(1'b1, 10'h354, 4);
    for (int i = 0; i < 4; i++) push_word(SYNC);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_offset0: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_junk_prefix();
    do_reset();
    for (int i = 0; i < 3; i++) bit_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) push_word(SYNC);
    push_exp(1'b1, 10'h354, 4);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (phase !== 4'd2) begin
      failures++;
      $display("FAIL phase_offset3: got %0d required 2", phase);
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL locked_offset3: got %b required 1", locked);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_offset3: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    lock_seq();
    push_exp(1'b0, FILL, 1024);
    for (int i = 0; i < 1024; i++) push_word(FILL);
    send_bits(1);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: got locked=%b required 1 before 1024th word", locked);
    end
    send_bits(0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_drop: got locked=%b required 0 at 1024th word", locked);
    end
    for (int i = 0; i < 5; i++) push_word(FILL);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after: got %0d words missing locked=%b, required 0 and 0", exp_q.size(), locked);
    end
  endtask

  task automatic test_verify_break();
    logic b0;
    logic b1;
    do_reset();
    push_word(SYNC);
    push_word(SYNC);
    push_word(10'h000);
    send_bits(0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL verify_break: got locked=%b required 0", locked);
    end
    for (int i = 0; i < 4; i++) push_word(SYNC);
    send_bits(1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_early: got locked=%b required 0 before 4th clean token", locked);
    end
    b0 = bit_q.pop_front();
    b1 = bit_q.pop_front();
    send_pair({b1, b0}, 1'b0);
    checks++;
    if (locked !== 1'b1 || phase !== 4'd9) begin
      failures++;
      $display("FAIL relock: got locked=%b phase=%0d, required 1 and 9", locked, phase);
    end
    push_exp(1'b1, 10'h354, 2);
    push_word(SYNC);
    push_word(SYNC);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_relock: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_realign();
    logic b0;
    logic b1;
    do_reset();
    lock_seq();
    push_exp(1'b1, 10'h354, 1);
    push_word(SYNC);
    push_word(SYNC);
    send_bits(1);
    // last pair carries the boundary bit; realign must suppress that word
    b0 = bit_q.pop_front();
    b1 = bit_q.pop_front();
    send_pair({b1, b0}, 1'b1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL realign_drop: got locked=%b required 0", locked);
    end
    checks++;
    if (phase !== 4'd9) begin
      failures++;
      $display("FAIL realign_phase_hold: got %0d required 9", phase);
    end
    for (int i = 0; i < 4; i++) push_word(SYNC);
    send_bits(1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL realign_relock_early: got locked=%b required 0", locked);
    end
    send_bits(0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL realign_relock: got locked=%b required 1", locked);
    end
    push_exp(1'b1, 10'h354, 1);
    push_word(SYNC);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_realign: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    lock_seq();
    push_exp(1'b1, 10'h354, 1);
    push_word(SYNC);
    push_word(SYNC);
    send_bits(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({word, word_vld, sync, locked, phase} !== 17'd0) begin
      failures++;
      $display("FAIL async_reset: got word=%h vld=%b sync=%b locked=%b phase=%0d, required all 0",
               word, word_vld, sync, locked, phase);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_before_reset: got %0d words missing, required 0", exp_q.size());
    end
    bit_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) bit_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) push_word(SYNC);
    push_exp(1'b1, 10'h354, 4);
    send_bits(0);
    @(negedge clk); #1;
    checks++;
    if (phase !== 4'd2 || locked !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_relock: got phase=%0d locked=%b missing=%0d, required 2 1 0",
               phase, locked, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_lock_offset0();
    test_junk_prefix();
    test_timeout();
    test_verify_break();
    test_realign();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ides_word_align.md
IDES_WORD_ALIGN -- requirements
Module: ides_word_align

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 10'b1101010100, the alignment token (word bit 0 = first-received bit).
REQ-002 SHALL have parameter LOCK_COUNT, default 4, the number of consecutive aligned SYNC_WORD matches needed to lock (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_WORDS, default 1024, the number of words allowed without an aligned SYNC_WORD before lock is dropped (range 2..65535).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port data_i, input, 2 bits: two serial bits per clock, already captured by the DDR input cell; data_i[0] is the earlier bit (LSB-first stream).
REQ-007 SHALL have port realign_i, input, 1 bit: a 1-cycle pulse that forces re-hunt.
REQ-008 SHALL have port word_o, output, 10 bits: the aligned word, bit 0 earliest.
REQ-009 SHALL have port word_vld_o, output, 1 bit: a 1-cycle strobe marking word_o valid, asserted only while locked.
REQ-010 SHALL have port sync_o, output, 1 bit: asserted with word_vld_o when word_o == SYNC_WORD.
REQ-011 SHALL have port locked_o, output, 1 bit: high in state LOCKED.
REQ-012 SHALL have port phase_o, output, 4 bits: the selected bit offset, 0..9.

Function
REQ-013 SHALL number the received bits n = 0,1,2,... from reset release, with data_i[0] = bit 2k and data_i[1] = bit 2k+1 at the k-th sampling edge; SHALL keep a history of at least the last 11 bits.
REQ-014 SHALL define window W(n) = bits n-9..n, with bit n-9 mapped to word bit 0.
REQ-015 SHALL use three states: HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-016 In HUNT, SHALL test both W(2k) and W(2k+1) against SYNC_WORD every sampling edge, so all 10 offsets are covered in 5 clocks; windows with n < 9 are never tested.
REQ-017 On a HUNT match, SHALL set phase = n mod 10, match count = 1, and go to VERIFY; if both candidates match, the lower n wins.
REQ-018 SHALL define word boundaries as bits with n mod 10 == phase, which fall exactly every 5 clocks.
REQ-019 In VERIFY, at each boundary: if W(n) == SYNC_WORD, increment the count and enter LOCKED when it reaches LOCK_COUNT; otherwise go to HUNT and clear the count.
REQ-020 With LOCK_COUNT = 1, SHALL go HUNT -> LOCKED directly on the first match.
REQ-021 In LOCKED, at each boundary: output W(n) on word_o with word_vld_o = 1, and sync_o = 1 if W(n) == SYNC_WORD.
REQ-022 In LOCKED, SHALL count words since the last aligned SYNC_WORD, resetting to 0 on a match; when the count reaches TIMEOUT_WORDS, go to HUNT with no further word_vld_o.
REQ-023 SHALL treat misaligned SYNC_WORD matches in LOCKED as no event; phase is never changed while locked.
REQ-024 SHALL register outputs: word_o/word_vld_o/sync_o assert on the clock following the edge that sampled the boundary bit (1-cycle latency); word_vld_o is high for exactly 1 cycle per word.
REQ-025 The first word_vld_o after lock SHALL be the boundary after the one completing LOCK_COUNT.
REQ-026 On realign_i = 1, SHALL go to HUNT next edge from any state, clear the counts and suppress word_vld_o; realign_i takes priority over a simultaneous match, boundary, or timeout.
REQ-027 A match in the same cycle as realign_i SHALL be ignored; hunting starts on the following edge.
REQ-028 phase_o SHALL hold the last selected phase until a new HUNT match occurs.
REQ-029 All counters SHALL saturate and never wrap.

Reset
REQ-030 While rst_n_i = 0, asynchronously: state = HUNT, word_o = 0, word_vld_o = 0, sync_o = 0, locked_o = 0, phase_o = 0, all counters and bit history cleared.
REQ-031 Reset asserted mid-word or while LOCKED SHALL abort immediately; after release, bit numbering restarts at n = 0.
REQ-032 Reset release SHALL be synchronized externally to clk_i; the block assumes no internal release synchronizer.

Verification
REQ-033 Repeated SYNC_WORD at offset 0, defaults: locked_o rises after the 4th token; word_vld_o then every 5 clocks with word_o = 10'h354 and sync_o = 1; phase_o = 9.
REQ-034 Same stream prefixed by 3 junk bits: locks with phase_o = 2; words identical to REQ-033.
REQ-035 After lock, 1024 words of 10'h0F0 with no token: locked_o falls at the 1024th word; no word_vld_o afterward.
REQ-036 Verify broken by one corrupted token after 2 matches: returns to HUNT; relocks after 4 further clean tokens.
REQ-037 realign_i pulsed while LOCKED coincident with a boundary: that word is suppressed; locked_o = 0 next cycle; relock follows the REQ-033 sequence.
REQ-038 rst_n_i asserted for 1 cycle mid-word while locked: all outputs 0 asynchronously; after release, state = HUNT and the first match is counted from n = 9 onward.
